// File: rtl/joypad_irq_if.sv
// Joypad column pins, interrupt handshake and status signals for joypad_irq.
interface joypad_irq_if;
  logic       p10_c;
  logic       p11_c;
  logic       p12_c;
  logic       p13_c;
  logic       irq_ack;
  logic       irq_req;
  logic       wake;
  logic       pressed;
  logic [1:0] state;

  modport slave (
    input  p10_c, p11_c, p12_c, p13_c, irq_ack,
    output irq_req, wake, pressed, state
  );

  modport master (
    output p10_c, p11_c, p12_c, p13_c, irq_ack,
    input  irq_req, wake, pressed, state
  );
endinterface

// File: rtl/joypad_irq.sv
// Joypad line synchronizer, press/release debouncer and level interrupt request.
//   state   | meaning
//   IDLE    | no key down, waiting for any line low
//   ARM     | line low, counting stable samples before accepting a press
//   HELD    | press accepted, interrupt raised once on entry
//   RELEASE | lines high, counting stable samples before accepting release
module joypad_irq #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  joypad_irq_if.slave  jp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] DEB = 8'(DEBOUNCE_CYCLES);

  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic       wake_q, wake_d;
  logic       irq_q, irq_d;
  logic [7:0] cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic       line_low;
  logic       irq_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'hf;
      sync2_q <= 4'hf;
      wake_q  <= 1'b0;
      irq_q   <= 1'b0;
      cnt_q   <= 8'd0;
      state_q <= IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      wake_q  <= wake_d;
      irq_q   <= irq_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    sync1_d  = {jp.p13_c, jp.p12_c, jp.p11_c, jp.p10_c};
    sync2_d  = sync1_q;
    line_low = ~&sync2_q;
    wake_d   = line_low;
    state_d  = state_q;
    cnt_d    = cnt_q;
    irq_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_low) begin
          state_d = ARM;
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = 8'd0;
        end
      end
      ARM: begin
        if (!line_low) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == DEB) begin
          state_d = HELD;
          irq_set = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (!line_low) begin
          state_d = RELEASE;
          cnt_d   = 8'd1;
        end
      end
      RELEASE: begin
        // A line going low again is release bounce: back to HELD, no new interrupt.
        if (line_low) begin
          state_d = HELD;
        end else if (cnt_q == DEB) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // Set beats a coincident acknowledge; the request is independent of the FSM afterwards.
    irq_d = irq_set | (irq_q & ~jp.irq_ack);
  end

  assign jp.irq_req = irq_q;
  assign jp.wake    = wake_q;
  assign jp.pressed = (state_q == HELD) || (state_q == RELEASE);
  assign jp.state   = state_q;

endmodule
